instr_decode_ctrl: RTL and testbench

- Decode/control stage directly downstream of the program-counter/instruction-memory block.
- Registers the 20-bit instruction word each cycle and decodes it into datapath controls.
- Drives pc_mux_sel/jmp_loc back to the PC block for JMP, BEQ and HALT.
- The PC block has no stall input, so control transfers are resolved by squashing instructions in the register, not by holding the PC.

---
 rtl/instr_decode_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_instr_decode_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_decode_ctrl.sv
// Decode/control stage: registers the IM word, decodes datapath controls and resolves JMP/BEQ/HALT.
// Optional macro DECODE_ISSUE_CNT_EN adds a saturating issue counter on port issue_count.
module instr_decode_ctrl #(
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              Clk1,
    input  logic              Rst_n,
    input  logic [19:0]       Ins,
    input  logic [ADDR_W-1:0] current_address,
    input  logic              zero_flag,
    output logic              pc_mux_sel,
    output logic [ADDR_W-1:0] jmp_loc,
    output logic [1:0]        alu_op,
    output logic [3:0]        rd_addr,
    output logic [3:0]        rs_addr,
    output logic [3:0]        rt_addr,
    output logic [7:0]        imm,
    output logic              alu_src_imm,
    output logic              reg_we,
    output logic              mem_re,
    output logic              mem_we,
    output logic              halted,
    output logic              illegal_op
`ifdef DECODE_ISSUE_CNT_EN
    ,
    output logic [CNT_W-1:0]  issue_count
`endif
);

    typedef enum logic [1:0] {S_RUN, S_BR_WAIT, S_HALT} state_e;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_ADDI = 4'h5;
    localparam logic [3:0] OP_LW   = 4'h6;
    localparam logic [3:0] OP_SW   = 4'h7;
    localparam logic [3:0] OP_BEQ  = 4'h8;
    localparam logic [3:0] OP_JMP  = 4'h9;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [1:0] ALU_ADD = 2'd0;
    localparam logic [1:0] ALU_SUB = 2'd1;

    logic [19:0]       ir_q, ir_d;
    logic [ADDR_W-1:0] ir_pc_q, ir_pc_d;
    logic              ir_valid_q, ir_valid_d;
    logic [ADDR_W-1:0] br_tgt_q, br_tgt_d;
    state_e            state_q, state_d;

    logic [3:0] op;
    logic       is_ctrl;
    logic       issued;

    assign op      = ir_q[19:16];
    assign is_ctrl = (op == OP_BEQ) || (op == OP_JMP) || (op == OP_HALT);

    // NOTE: every output and _d signal gets a default first, so no path through the case tree leaves one unassigned and infers a latch.
    always_comb begin
        pc_mux_sel  = 1'b0;
        jmp_loc     = '0;
        alu_op      = ALU_ADD;
        rd_addr     = '0;
        rs_addr     = '0;
        rt_addr     = '0;
        imm         = '0;
        alu_src_imm = 1'b0;
        reg_we      = 1'b0;
        mem_re      = 1'b0;
        mem_we      = 1'b0;
        halted      = 1'b0;
        illegal_op  = 1'b0;
        issued      = 1'b0;
        state_d     = state_q;
        br_tgt_d    = br_tgt_q;

        case (state_q)
            S_HALT: begin
                // br_tgt_q holds the HALT's own address, so the PC spins on it
                halted     = 1'b1;
                pc_mux_sel = 1'b1;
                jmp_loc    = br_tgt_q;
            end
            default: begin
                if (state_q == S_BR_WAIT) state_d = S_RUN;
                if (ir_valid_q) begin
                    if (state_q == S_BR_WAIT && is_ctrl) begin
                        illegal_op = 1'b1;
                    end else begin
                        case (op)
                            OP_NOP: ;
                            OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                                alu_op  = 2'(op - 4'd1);
                                rd_addr = ir_q[15:12];
                                rs_addr = ir_q[11:8];
                                rt_addr = ir_q[7:4];
                                reg_we  = 1'b1;
                                issued  = 1'b1;
                            end
                            OP_ADDI, OP_LW: begin
                                rd_addr     = ir_q[15:12];
                                rs_addr     = ir_q[11:8];
                                imm         = ir_q[7:0];
                                alu_src_imm = 1'b1;
                                reg_we      = 1'b1;
                                mem_re      = (op == OP_LW);
                                issued      = 1'b1;
                            end
                            OP_SW: begin
                                rt_addr     = ir_q[15:12];
                                rs_addr     = ir_q[11:8];
                                imm         = ir_q[7:0];
                                alu_src_imm = 1'b1;
                                mem_we      = 1'b1;
                                issued      = 1'b1;
                            end
                            OP_BEQ: begin
                                alu_op   = ALU_SUB;
                                rt_addr  = ir_q[15:12];
                                rs_addr  = ir_q[11:8];
                                imm      = ir_q[7:0];
                                br_tgt_d = ADDR_W'(ir_q[7:0]);
                                state_d  = S_BR_WAIT;
                                issued   = 1'b1;
                            end
                            OP_JMP: begin
                                pc_mux_sel = 1'b1;
                                jmp_loc    = ADDR_W'(ir_q[7:0]);
                                issued     = 1'b1;
                            end
                            OP_HALT: begin
                                br_tgt_d = ir_pc_q;
                                state_d  = S_HALT;
                                issued   = 1'b1;
                            end
                            default: illegal_op = 1'b1;
                        endcase
                    end
                    // Delay slot has issued above; the branch resolves on the compare result now
                    if (state_q == S_BR_WAIT && zero_flag) begin
                        pc_mux_sel = 1'b1;
                        jmp_loc    = br_tgt_q;
                    end
                end
            end
        endcase
    end

    always_comb begin
        ir_d       = Ins;
        ir_pc_d    = current_address;
        ir_valid_d = ~pc_mux_sel;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clk1) begin
        if (!Rst_n) begin
            ir_q       <= '0;
            ir_pc_q    <= '0;
            ir_valid_q <= 1'b0;
            br_tgt_q   <= '0;
            state_q    <= S_RUN;
        end else begin
            ir_q       <= ir_d;
            ir_pc_q    <= ir_pc_d;
            ir_valid_q <= ir_valid_d;
            br_tgt_q   <= br_tgt_d;
            state_q    <= state_d;
        end
    end

`ifdef DECODE_ISSUE_CNT_EN
    logic [CNT_W-1:0] issue_cnt_q, issue_cnt_d;

    always_comb begin
        issue_cnt_d = issue_cnt_q;
        if (issued && issue_cnt_q != '1) issue_cnt_d = issue_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge Clk1) begin
        if (!Rst_n) issue_cnt_q <= '0;
        else        issue_cnt_q <= issue_cnt_d;
    end

    assign issue_count = issue_cnt_q;
`else
    logic unused_ok;
    assign unused_ok = &{1'b0, issued, CNT_W[0]};
`endif

endmodule

// File: tb/tb_instr_decode_ctrl.sv
// Scoreboard bench for instr_decode_ctrl: the bench plays the PC/IM block and predicts every output cycle.
// Build with +define+DECODE_ISSUE_CNT_EN to also check issue_count.
module tb_instr_decode_ctrl;

  localparam int ADDR_W = 8;
  localparam int CNT_W  = 16;
  localparam int N_CYC  = 4000;

  logic              Clk1 = 1'b0;
  logic              Rst_n;
  logic [19:0]       Ins;
  logic [ADDR_W-1:0] current_address;
  logic              zero_flag;
  logic              pc_mux_sel;
  logic [ADDR_W-1:0] jmp_loc;
  logic [1:0]        alu_op;
  logic [3:0]        rd_addr, rs_addr, rt_addr;
  logic [7:0]        imm;
  logic              alu_src_imm, reg_we, mem_re, mem_we, halted, illegal_op;
`ifdef DECODE_ISSUE_CNT_EN
  logic [CNT_W-1:0]  issue_count;
`endif

  instr_decode_ctrl #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .Clk1(Clk1), .Rst_n(Rst_n), .Ins(Ins), .current_address(current_address),
    .zero_flag(zero_flag), .pc_mux_sel(pc_mux_sel), .jmp_loc(jmp_loc), .alu_op(alu_op),
    .rd_addr(rd_addr), .rs_addr(rs_addr), .rt_addr(rt_addr), .imm(imm),
    .alu_src_imm(alu_src_imm), .reg_we(reg_we), .mem_re(mem_re), .mem_we(mem_we),
    .halted(halted), .illegal_op(illegal_op)
`ifdef DECODE_ISSUE_CNT_EN
    , .issue_count(issue_count)
`endif
  );

  always #5 Clk1 = ~Clk1;

  typedef struct packed {
    logic             pc_mux_sel;
    logic [7:0]       jmp_loc;
    logic [1:0]       alu_op;
    logic [3:0]       rd, rs, rt;
    logic [7:0]       imm;
    logic             alu_src_imm, reg_we, mem_re, mem_we, halted, illegal_op;
`ifdef DECODE_ISSUE_CNT_EN
    logic [CNT_W-1:0] issue_count;
`endif
  } out_t;

  out_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input out_t act, input out_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compares whatever the DUT presents against the oldest prediction
  int   mon_cyc = 0;
  out_t act;
  always @(negedge Clk1) begin
    if (exp_q.size() > 0) begin
      act = {pc_mux_sel, jmp_loc, alu_op, rd_addr, rs_addr, rt_addr, imm,
             alu_src_imm, reg_we, mem_re, mem_we, halted, illegal_op
`ifdef DECODE_ISSUE_CNT_EN
             , issue_count
`endif
             };
      check($sformatf("cycle %0d", mon_cyc), act, exp_q.pop_front());
      mon_cyc++;
    end
  end

  // Reference model: architectural view of the stage
  logic [19:0] imem [256];
  logic [19:0] m_ir;
  logic [7:0]  m_ir_pc, m_pc, m_br_tgt, m_halt_pc;
  bit          m_valid, m_slot, m_halted;
  logic [15:0] m_cnt;
  out_t        e;
  bit          e_issued, n_slot, n_halted;
  logic [7:0]  n_br_tgt, n_halt_pc;
  bit          checking = 0;
  int          ph = 0, next_ph = 0, phase_cyc = 0, halt_cnt = 0;

  function automatic logic [19:0] rand_instr();
    int r;
    logic [3:0] op;
    r = $urandom_range(0, 99);
    if (r < 40)      op = 4'($urandom_range(0, 7));
    else if (r < 55) op = 4'h8;
    else if (r < 65) op = 4'h9;
    else if (r < 78) op = 4'($urandom_range(10, 14));
    else if (r < 81) op = 4'hF;
    else             op = 4'($urandom_range(1, 4));
    return {op, 16'($urandom)};
  endfunction

  task automatic load_program(input int p);
    for (int i = 0; i < 256; i++) imem[i] = (p < 2) ? 20'h00000 : rand_instr();
    if (p < 2) begin
      imem[8'h00] = 20'h13120;  // ADD r3,r1,r2
      imem[8'h01] = 20'h14120;
      imem[8'h02] = 20'h15120;
      imem[8'h03] = 20'h16120;
      imem[8'h04] = 20'h90006;  // JMP 0x06
      imem[8'h05] = 20'h17120;  // squashed
      imem[8'h06] = 20'h8120A;  // BEQ -> 0x0A
      imem[8'h07] = 20'h5410F;  // ADDI delay slot
      imem[8'h08] = 20'h18120;
      imem[8'h09] = 20'hB0000;  // illegal
      imem[8'h0A] = 20'hB1234;  // illegal
      imem[8'h0B] = 20'hF0000;  // HALT
    end
  endtask

  function automatic void compute_expect();
    logic [3:0] op;
    bit is_ctrl;
    op = m_ir[19:16];
    e = '0;
    e_issued = 0;
    n_slot = 0;
    n_halted = m_halted;
    n_br_tgt = m_br_tgt;
    n_halt_pc = m_halt_pc;
`ifdef DECODE_ISSUE_CNT_EN
    e.issue_count = m_cnt;
`endif
    if (m_halted) begin
      e.halted = 1;
      e.pc_mux_sel = 1;
      e.jmp_loc = m_halt_pc;
      return;
    end
    is_ctrl = (op == 4'h8) || (op == 4'h9) || (op == 4'hF);
    if (m_valid) begin
      if ((op >= 4'hA && op <= 4'hE) || (m_slot && is_ctrl)) begin
        e.illegal_op = 1;
      end else if (op != 4'h0) begin
        e_issued = 1;
        if (op <= 4'h4) begin
          e.alu_op = 2'(op - 4'd1);
          e.rd = m_ir[15:12]; e.rs = m_ir[11:8]; e.rt = m_ir[7:4];
          e.reg_we = 1;
        end else if (op <= 4'h7) begin
          e.alu_src_imm = 1;
          e.rs = m_ir[11:8];
          e.imm = m_ir[7:0];
          if (op == 4'h7) begin
            e.rt = m_ir[15:12];
            e.mem_we = 1;
          end else begin
            e.rd = m_ir[15:12];
            e.reg_we = 1;
            e.mem_re = (op == 4'h6);
          end
        end else if (op == 4'h8) begin
          e.alu_op = 2'd1;
          e.rt = m_ir[15:12]; e.rs = m_ir[11:8]; e.imm = m_ir[7:0];
          n_slot = 1;
          n_br_tgt = m_ir[7:0];
        end else if (op == 4'h9) begin
          e.pc_mux_sel = 1;
          e.jmp_loc = m_ir[7:0];
        end else begin
          n_halted = 1;
          n_halt_pc = m_ir_pc;
        end
      end
      if (m_slot && zero_flag) begin
        e.pc_mux_sel = 1;
        e.jmp_loc = m_br_tgt;
      end
    end
  endfunction

  task automatic model_edge(input bit rst_low);
    if (rst_low) begin
      m_ir = '0; m_ir_pc = '0; m_valid = 0; m_slot = 0; m_halted = 0;
      m_br_tgt = '0; m_halt_pc = '0; m_cnt = '0; m_pc = '0;
      ph = next_ph;
      phase_cyc = 0;
      load_program(ph);
      checking = 1;
    end else begin
      if (e_issued && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      m_ir = Ins;
      m_ir_pc = current_address;
      m_valid = !e.pc_mux_sel;
      m_slot = n_slot;
      m_halted = n_halted;
      m_br_tgt = n_br_tgt;
      m_halt_pc = n_halt_pc;
      m_pc = e.pc_mux_sel ? e.jmp_loc : m_pc + 8'd1;
      phase_cyc++;
    end
  endtask

  initial begin
    Rst_n = 1'b0;
    Ins = '0;
    current_address = '0;
    zero_flag = 1'b0;
    e = '0;
    e_issued = 0;
    m_pc = '0;
    load_program(0);
    for (int cyc = 0; cyc < N_CYC; cyc++) begin
      @(posedge Clk1);
      #1;
      model_edge(!Rst_n);
      halt_cnt = m_halted ? halt_cnt + 1 : 0;
      Rst_n = 1'b1;
      if (cyc == 0) begin
        Rst_n = 1'b0;
      end else if (halt_cnt >= 4 || phase_cyc >= 300 ||
                   (ph >= 2 && $urandom_range(0, 149) == 0)) begin
        Rst_n = 1'b0;
        next_ph = ph + 1;
      end
      zero_flag = (ph == 0) ? 1'b1 : (ph == 1) ? 1'b0 : 1'($urandom_range(0, 1));
      Ins = imem[m_pc];
      current_address = m_pc;
      compute_expect();
      if (checking) exp_q.push_back(e);
    end
    @(negedge Clk1);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
